// File: rtl/rib_arbiter_pkg.sv
// Shared types and constants for the system-bus arbiter: FSM states, master
// indices, slave base nibbles and the error read-data value.
package rib_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } rib_state_e;

    localparam int M_JTAG = 0;
    localparam int M_UART = 1;
    localparam int M_EX   = 2;
    localparam int M_PC   = 3;

    localparam logic [3:0] S_ROM   = 4'h0;
    localparam logic [3:0] S_RAM   = 4'h1;
    localparam logic [3:0] S_TIMER = 4'h2;
    localparam logic [3:0] S_UART  = 4'h3;
    localparam logic [3:0] S_GPIO  = 4'h4;
    localparam logic [3:0] S_SPI   = 4'h5;

    localparam logic [31:0] ERR_DATA = 32'h0;

    // Width of a binary index or counter able to hold n distinct values (min 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rib_prio_enc.sv
// Fixed-priority encoder: binary index of the lowest set request bit plus a
// valid flag. Purely combinational.
module rib_prio_enc
    import rib_arbiter_pkg::*;
#(
    parameter int NM = 4,
    parameter int IW = idx_width(NM)
) (
    input  logic [NM-1:0] req_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        idx_o = '0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/rib_arbiter.sv
// Registered system-bus arbiter and slave decoder with per-access timeout and
// core hold generation.
//
// state   | meaning
// IDLE    | arbitrate; latch winner's we/addr/data
// BUSY    | drive selected slave, wait for ack / decode error / timeout
// RESP    | pulse ack (and err) to the granted master with captured data
module rib_arbiter
    import rib_arbiter_pkg::*;
#(
    parameter int NM      = 4,
    parameter int NS      = 6,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_req_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM*32-1:0] m_addr_i,
    input  logic [NM*32-1:0] m_data_i,
    output logic [31:0]      m_data_o,
    output logic [NM-1:0]    m_ack_o,
    output logic             m_err_o,
    output logic [NS-1:0]    s_req_o,
    output logic             s_we_o,
    output logic [31:0]      s_addr_o,
    output logic [31:0]      s_data_o,
    input  logic [NS*32-1:0] s_data_i,
    input  logic [NS-1:0]    s_ack_i,
    output logic             hold_flag_o
);

    localparam int GW = idx_width(NM);
    localparam int CW = idx_width(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    rib_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [GW-1:0] pe_idx;
    logic          pe_valid;
    logic          req_we;
    logic [31:0]   req_addr, req_wdata;
    logic [3:0]    sel;
    logic          sel_ok;
    logic          slv_ack;
    logic [31:0]   slv_rdata;
    logic          timeout_hit;

    rib_prio_enc #(.NM(NM), .IW(GW)) u_prio_enc (
        .req_i  (m_req_i),
        .idx_o  (pe_idx),
        .valid_o(pe_valid)
    );

    always_comb begin
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int m = 0; m < NM; m++) begin
            if (int'(pe_idx) == m) begin
                req_we    = m_we_i[m];
                req_addr  = m_addr_i[m*32 +: 32];
                req_wdata = m_data_i[m*32 +: 32];
            end
        end
    end

    assign sel    = addr_q[31:28];
    assign sel_ok = int'(sel) < NS;

    always_comb begin
        slv_ack   = 1'b0;
        slv_rdata = '0;
        for (int s = 0; s < NS; s++) begin
            if (int'(sel) == s) begin
                slv_ack   = s_ack_i[s];
                slv_rdata = s_data_i[s*32 +: 32];
            end
        end
    end

    // Fires on the last allowed BUSY cycle, so the request is held exactly TIMEOUT cycles.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pe_valid) begin
                    grant_d = pe_idx;
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!sel_ok) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (slv_ack) begin
                    rdata_d = slv_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (timeout_hit) begin
                        rdata_d = ERR_DATA;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        m_ack_o  = '0;
        m_data_o = '0;
        m_err_o  = 1'b0;
        s_req_o  = '0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        if (state_q == ST_RESP) begin
            for (int m = 0; m < NM; m++) begin
                m_ack_o[m] = (int'(grant_q) == m);
            end
            m_data_o = rdata_q;
            m_err_o  = err_q;
        end
        if ((state_q == ST_BUSY) && sel_ok) begin
            for (int s = 0; s < NS; s++) begin
                s_req_o[s] = (int'(sel) == s);
            end
            s_we_o   = we_q;
            s_addr_o = {4'h0, addr_q[27:0]};
            s_data_o = wdata_q;
        end
    end

    // A core master stops being held in the cycle its own ack is presented.
    assign hold_flag_o = m_req_i[M_JTAG] | m_req_i[M_UART]
                       | ((state_q != ST_IDLE) && (int'(grant_q) < M_EX))
                       | (|(m_req_i[NM-1:M_EX] & ~m_ack_o[NM-1:M_EX]));

endmodule

// File: tb/tb_rib_arbiter.sv
// Scoreboard bench for rib_arbiter: behavioural slaves, directed timing checks
// and randomized request rounds.
module tb_rib_arbiter;
    import rib_arbiter_pkg::*;

    localparam int NM = 4;
    localparam int NS = 6;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NM-1:0]    m_req_i = '0;
    logic [NM-1:0]    m_we_i = '0;
    logic [NM*32-1:0] m_addr_i = '0;
    logic [NM*32-1:0] m_data_i = '0;
    logic [31:0]      m_data_o;
    logic [NM-1:0]    m_ack_o;
    logic             m_err_o;
    logic [NS-1:0]    s_req_o;
    logic             s_we_o;
    logic [31:0]      s_addr_o;
    logic [31:0]      s_data_o;
    logic [NS*32-1:0] s_data_i;
    logic [NS-1:0]    s_ack_i = '0;
    logic             hold_flag_o;

    rib_arbiter #(.NM(NM), .NS(NS), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_req_i    (m_req_i),
        .m_we_i     (m_we_i),
        .m_addr_i   (m_addr_i),
        .m_data_i   (m_data_i),
        .m_data_o   (m_data_o),
        .m_ack_o    (m_ack_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_we_o     (s_we_o),
        .s_addr_o   (s_addr_o),
        .s_data_o   (s_data_o),
        .s_data_i   (s_data_i),
        .s_ack_i    (s_ack_i),
        .hold_flag_o(hold_flag_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    exp_t          slv_e;
    int            n_tests = 0;
    int            n_fail = 0;
    int            lat_cfg[NS];
    int            lat_cnt[NS];
    logic [NS-1:0] act = '0;
    logic [NS-1:0] dead = '0;
    logic [NM-1:0] ack_smp;

    function automatic logic [31:0] slv_word(input int s, input logic [31:0] a);
        return (32'(s) << 28) ^ a ^ 32'hC3A5_1E00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act_v, exp_v);
        end
    endtask

    // Expected response straight from the decode rules: bad slave or dead slave -> err with 0.
    function automatic exp_t mk_exp(input int m, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata);
        exp_t e;
        int   sel;
        sel     = int'(addr[31:28]);
        e.m     = m;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.err   = 1'b1;
        e.rdata = 32'h0;
        if (sel < NS) begin
            if (!dead[sel]) begin
                e.err   = 1'b0;
                e.rdata = slv_word(sel, {4'h0, addr[27:0]});
            end
        end
        return e;
    endfunction

    always_comb begin
        s_data_i = '0;
        for (int s = 0; s < NS; s++) begin
            s_data_i[s*32 +: 32] = slv_word(s, s_addr_o);
        end
    end

    // Slaves: ack after lat_cfg BUSY cycles (0 = same cycle); dead slaves never ack.
    always @(negedge clk) begin
        for (int s = 0; s < NS; s++) begin
            if (!s_req_o[s]) begin
                act[s]     = 1'b0;
                s_ack_i[s] = 1'b0;
            end else if (!dead[s]) begin
                if (!act[s]) begin
                    act[s]     = 1'b1;
                    lat_cnt[s] = lat_cfg[s];
                end
                if (!s_ack_i[s]) begin
                    if (lat_cnt[s] == 0) begin
                        s_ack_i[s] = 1'b1;
                        if (exp_q.size() > 0) begin
                            slv_e = exp_q[0];
                            chk("slave_sel", 32'(s), 32'(slv_e.addr[31:28]));
                            chk("slave_req", 32'(s_req_o), 32'(1) << s);
                            chk("slave_addr", s_addr_o, {4'h0, slv_e.addr[27:0]});
                            chk("slave_we", 32'(s_we_o), 32'(slv_e.we));
                            chk("slave_wdata", s_data_o, slv_e.wdata);
                        end
                    end else begin
                        lat_cnt[s] = lat_cnt[s] - 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && (m_ack_o != '0)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got m_ack_o=%b, expected no ack", m_ack_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_master", 32'(m_ack_o), 32'(1) << mon_e.m);
                chk("ack_rdata", m_data_o, mon_e.rdata);
                chk("ack_err", 32'(m_err_o), 32'(mon_e.err));
            end
        end
    end

    // Advance to the next negedge; masters drop req right after the edge that ends their ack.
    task automatic step();
        @(posedge clk);
        ack_smp = m_ack_o;
        #1;
        m_req_i = m_req_i & ~ack_smp;
        @(negedge clk);
    endtask

    task automatic issue(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        m_we_i[m]            = we;
        m_addr_i[m*32 +: 32] = addr;
        m_data_i[m*32 +: 32] = wdata;
        exp_q.push_back(mk_exp(m, we, addr, wdata));
        m_req_i[m] = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            step();
            i++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d responses outstanding after %0d cycles, expected 0",
                     exp_q.size(), budget);
            exp_q.delete();
            m_req_i = '0;
        end
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_j, t_p, n_hi, got;
        logic [3:0] mask;
        for (int s = 0; s < NS; s++) begin
            lat_cfg[s] = 0;
            lat_cnt[s] = 0;
        end
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_m_ack", 32'(m_ack_o), 32'h0);
        chk("rst_s_req", 32'(s_req_o), 32'h0);
        chk("rst_m_data", m_data_o, 32'h0);
        chk("rst_m_err", 32'(m_err_o), 32'h0);
        chk("rst_s_bus", s_addr_o | s_data_o | 32'(s_we_o), 32'h0);
        chk("rst_hold", 32'(hold_flag_o), 32'h0);
        rst = 1'b1;
        step();
        step();

        // Core ex read from RAM, same-cycle ack
        lat_cfg[1] = 0;
        issue(M_EX, 1'b0, {S_RAM, 28'h000_0010}, 32'h0);
        #1 chk("t1_hold_req", 32'(hold_flag_o), 32'h1);
        step();
        chk("t1_s_req", 32'(s_req_o), 32'h02);
        chk("t1_s_addr", s_addr_o, 32'h0000_0010);
        chk("t1_busy_no_ack", 32'(m_ack_o), 32'h0);
        chk("t1_hold_busy", 32'(hold_flag_o), 32'h1);
        step();
        chk("t1_m_ack", 32'(m_ack_o), 32'h4);
        chk("t1_m_data", m_data_o, slv_word(1, 32'h0000_0010));
        chk("t1_resp_s_req", 32'(s_req_o), 32'h0);
        chk("t1_hold_resp", 32'(hold_flag_o), 32'h0);
        wait_drain(20);

        // jtag and core pc in the same cycle
        lat_cfg[0] = 0;
        issue(M_JTAG, 1'b0, {S_ROM, 28'h000_0100}, 32'h0);
        issue(M_PC, 1'b0, {S_RAM, 28'h000_0020}, 32'h0);
        t_j = -1;
        t_p = -1;
        for (int c = 1; c <= 12 && t_p < 0; c++) begin
            step();
            if (m_ack_o[M_JTAG]) t_j = c;
            if (m_ack_o[M_PC]) t_p = c;
            else chk("t2_hold", 32'(hold_flag_o), 32'h1);
        end
        chk("t2_jtag_cycle", 32'(t_j), 32'd2);
        chk("t2_pc_gap", 32'(t_p - t_j), 32'd3);
        wait_drain(20);

        // Write to UART slave with a slow ack
        lat_cfg[3] = 4;
        issue(M_EX, 1'b1, {S_UART, 28'h000_0004}, 32'h55);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_s_req", 32'(s_req_o), 32'h08);
            chk("t3_s_we", 32'(s_we_o), 32'h1);
            chk("t3_s_data", s_data_o, 32'h55);
        end
        step();
        chk("t3_m_ack", 32'(m_ack_o), 32'h4);
        wait_drain(20);

        // Decode error
        issue(M_UART, 1'b1, 32'h7000_0000, 32'hDEAD_BEEF);
        step();
        chk("t4_no_s_req", 32'(s_req_o), 32'h0);
        chk("t4_no_s_data", s_data_o | 32'(s_we_o), 32'h0);
        step();
        chk("t4_m_ack", 32'(m_ack_o), 32'h2);
        chk("t4_m_err", 32'(m_err_o), 32'h1);
        chk("t4_m_data", m_data_o, 32'h0);
        wait_drain(20);

        // Timeout on a GPIO that never acks
        dead[4] = 1'b1;
        issue(M_EX, 1'b0, {S_GPIO, 28'h000_0008}, 32'h0);
        n_hi = 0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            step();
            if (s_req_o[4]) n_hi++;
            else got = 1;
        end
        chk("t5_req_cycles", 32'(n_hi), 32'(TO));
        chk("t5_m_ack", 32'(m_ack_o), 32'h4);
        chk("t5_m_err", 32'(m_err_o), 32'h1);
        chk("t5_m_data", m_data_o, 32'h0);
        step();
        chk("t5_idle_ack", 32'(m_ack_o), 32'h0);
        chk("t5_idle_s_req", 32'(s_req_o), 32'h0);
        wait_drain(20);
        dead[4] = 1'b0;

        // jtag drops its request mid-access: still completes and is acked
        lat_cfg[2] = 2;
        issue(M_JTAG, 1'b0, {S_TIMER, 28'h000_0040}, 32'h0);
        step();
        m_req_i[M_JTAG] = 1'b0;
        #1 chk("t7_hold_dropped", 32'(hold_flag_o), 32'h1);
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            step();
            if (m_ack_o != '0) got = 1;
        end
        chk("t7_ack_after_drop", 32'(m_ack_o), 32'h1);
        wait_drain(20);

        // Reset during BUSY
        lat_cfg[1] = 3;
        issue(M_EX, 1'b0, {S_RAM, 28'h000_0080}, 32'h0);
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("t6_s_req", 32'(s_req_o), 32'h0);
        chk("t6_m_ack", 32'(m_ack_o), 32'h0);
        chk("t6_m_out", m_data_o | 32'(m_err_o), 32'h0);
        chk("t6_s_bus", s_addr_o | s_data_o | 32'(s_we_o), 32'h0);
        exp_q.delete();
        step();
        rst = 1'b1;
        exp_q.push_back(mk_exp(M_EX, 1'b0, {S_RAM, 28'h000_0080}, 32'h0));
        step();
        chk("t6_rearb_s_req", 32'(s_req_o), 32'h02);
        wait_drain(30);

        // Randomized rounds: all chosen masters request together in IDLE
        for (int r = 0; r < 40; r++) begin
            for (int s = 0; s < NS; s++) begin
                lat_cfg[s] = int'($urandom_range(0, 3));
            end
            dead = ($urandom_range(0, 4) == 0) ? 6'b010000 : 6'b000000;
            mask = 4'($urandom_range(1, 15));
            for (int m = 0; m < NM; m++) begin
                if (mask[m]) begin
                    issue(m, 1'($urandom_range(0, 1)),
                          {4'($urandom_range(0, 7)), 28'($urandom)}, $urandom);
                end
            end
            wait_drain(120);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
